uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
- Parametrised UART receiver, the successor to the fixed-format receiver.
- Configurable data width, optional parity (even/odd), 1 or 2 stop bits and oversampling ratio.
- Samples each bit at its midpoint, rejects start-bit glitches, reports parity, framing, break and overrun errors.
- Sits between the baud-rate generator (i_bd_tick) and the command/data parser in the TP3 datapath.

Parameters:
- DATA_BITS, 8, data bits per frame, legal 5..32, LSB received first.
- OVERSAMPLE, 16, i_bd_tick pulses per bit period, even, 8..32.
- PARITY_EN, 0, 1 = parity bit present after the data bits.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
- STOP_BITS, 1, number of stop bits, 1 or 2.

Ports:
- i_clk  input  1  system clock, all logic on its rising edge
- i_reset  input  1  synchronous, active-high reset
- i_rx  input  1  asynchronous serial line, idle high
- i_bd_tick  input  1  oversampling tick, one i_clk cycle wide
- o_rx_done  output  1  one-cycle pulse: frame complete, o_data and error flags valid
- o_data  output  DATA_BITS  last received word, held until the next o_rx_done
- o_parity_err  output  1  parity mismatch in last frame, held until the next o_rx_done
- o_frame_err  output  1  a stop bit sampled low in last frame, held until the next o_rx_done
- o_break  output  1  last frame was all-zero data with a low first stop bit, held until the next o_rx_done
- o_overrun  output  1  sticky; cleared only by i_reset
- i_rd_ack  input  1  consumer read o_data; clears the pending flag

Behaviour:
- Input synchronisation: i_rx passes through a 2-flop synchroniser before use, giving 2 cycles of latency. All references to "rx" below mean the synchronised value.
- Reset: state IDLE, all counters 0. o_data=0, all flags=0, o_rx_done=0. Synchroniser flops preset to 1. Reset mid-frame aborts the frame with no o_rx_done.
- Counters:
  - tick counter is $clog2(OVERSAMPLE) bits and advances only on i_bd_tick.
  - bit counter is $clog2(DATA_BITS) bits (at least 1 bit).
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: rx==0 -> START, tick counter=0. Ticks are ignored in this state.
  - START: on the tick where the counter equals OVERSAMPLE/2-1, sample rx.
    - rx==1 is a glitch -> IDLE, no flags set.
    - rx==0 -> DATA, tick counter=0, bit counter=0.
  - DATA: on the tick where the counter equals OVERSAMPLE-1, shift rx into the MSB of the shift register (right shift) and reset the tick counter. After bit DATA_BITS-1 -> PARITY if PARITY_EN, else STOP.
  - PARITY: sample at OVERSAMPLE-1. Error when (XOR of data ^ sampled bit ^ PARITY_ODD) != 0. -> STOP.
  - STOP: sample at OVERSAMPLE-1.
    - Any sampled 0 sets the frame-error candidate.
    - With STOP_BITS=2, both stop bits are sampled.
    - After the last stop sample -> IDLE immediately (mid-stop-bit), so a back-to-back start bit is caught.
- Commit: on the cycle after the last stop sample:
  - o_rx_done=1 for exactly one cycle.
  - o_data, o_parity_err, o_frame_err and o_break update together in that cycle.
- Pending and overrun:
  - Internal pending bit: set on commit, cleared by i_rd_ack.
  - Commit while pending==1 and no i_rd_ack in the same cycle sets o_overrun. New data still overwrites o_data.
  - Commit and i_rd_ack in the same cycle: no overrun; pending stays 1.
- i_bd_tick held constantly high is legal; timing then counts in i_clk cycles.
- o_rx_done must never assert in IDLE, START or DATA.

Decomposition:
- Package uart_pkg holds:
  - state localparams (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3-bit encoding);
  - parity-mode constants PAR_EVEN=0, PAR_ODD=1;
  - a function returning the tick-counter width for OVERSAMPLE.
- One natural sub-module: uart_rx_sync, the 2-flop synchroniser with preset-to-1 on i_reset. It is shared with future receivers.

Test Plan:
- Defaults, i_bd_tick every 4 clk, send 0xA5 (bits LSB-first 1,0,1,0,0,1,0,1, stop 1) -> one o_rx_done pulse, o_data=0xA5, all error flags 0.
- PARITY_EN=1 PARITY_ODD=0, send 0x07 with parity bit 0 (wrong, should be 1) -> o_data=0x07, o_parity_err=1; resend with parity 1 -> o_parity_err=0.
- Stop bit driven 0 for 0x3C -> o_frame_err=1. Then all-zero data with low stop and line held low -> o_break=1. After line returns high, a normal 0x55 frame is received correctly.
- Start glitch: i_rx low for 3 ticks then high -> FSM returns to IDLE, no o_rx_done, all outputs unchanged.
- Two frames 0x11, 0x22 back-to-back without i_rd_ack -> o_overrun=1, o_data=0x22. Repeat with i_rd_ack between frames -> o_overrun stays 0.
- DATA_BITS=32, STOP_BITS=2: send 0xDEADBEEF -> o_data=0xDEADBEEF. Apply i_reset mid-data-bit 12 -> no o_rx_done, o_data=0, state IDLE; the next frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receivers: state encoding,
// parity modes, error flag bundle and counter-width helpers.
package uart_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef struct packed {
    logic parity_err;
    logic frame_err;
    logic brk;
  } rx_flags_t;

  function automatic int tick_cnt_width(input int oversample);
    return (oversample > 2) ? $clog2(oversample) : 1;
  endfunction

  function automatic int bit_cnt_width(input int data_bits);
    return (data_bits > 2) ? $clog2(data_bits) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an idle-high serial line; both stages preset to 1
// on reset so no false start bit is seen when reset releases.
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_sync
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = i_async;
    sync_d = meta_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign o_sync = sync_q;

endmodule

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: midpoint sampling, start-glitch rejection,
// parity / framing / break / overrun reporting.
//   state  | meaning
//   IDLE   | line idle, waiting for rx low
//   START  | timing to start-bit midpoint, glitch check
//   DATA   | sampling data bits, LSB first
//   PARITY | sampling the parity bit
//   STOP   | sampling stop bit(s); last sample commits the frame
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_rx,
  input  logic                 i_bd_tick,
  output logic                 o_rx_done,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_break,
  output logic                 o_overrun,
  input  logic                 i_rd_ack
);

  localparam int TW = tick_cnt_width(OVERSAMPLE);
  localparam int BW = bit_cnt_width(DATA_BITS);
  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic PAR_MODE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;
  localparam logic TWO_STOP = (STOP_BITS == 2);

  logic rx;

  uart_rx_sync u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_async (i_rx),
    .o_sync  (rx)
  );

  logic [2:0]           state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  rx_flags_t            cand_q, cand_d;
  rx_flags_t            flags_q, flags_d;
  logic                 done_q, done_d;
  logic                 pending_q, pending_d;
  logic                 overrun_q, overrun_d;
  logic                 sample_end;
  logic                 commit;

  assign sample_end = i_bd_tick && (tick_q == TICK_END);

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    cand_d  = cand_q;
    commit  = 1'b0;
    if (i_bd_tick && (state_q != IDLE)) tick_d = tick_q + TW'(1);
    case (state_q)
      IDLE: begin
        if (!rx) begin
          state_d = START;
          tick_d  = '0;
        end
      end
      START: begin
        if (i_bd_tick && (tick_q == TICK_MID)) begin
          state_d = rx ? IDLE : DATA;
          tick_d  = '0;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (sample_end) begin
          tick_d  = '0;
          shift_d = {rx, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + BW'(1);
          if (bit_q == BIT_LAST) begin
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
            stop_d  = 1'b0;
            cand_d  = '0;
          end
        end
      end
      PARITY: begin
        if (sample_end) begin
          tick_d            = '0;
          cand_d.parity_err = ^shift_q ^ rx ^ PAR_MODE;
          state_d           = STOP;
        end
      end
      STOP: begin
        if (sample_end) begin
          tick_d = '0;
          if (!rx) cand_d.frame_err = 1'b1;
          if (!stop_q) cand_d.brk = !rx && (shift_q == '0);
          // Leave mid-stop-bit so a back-to-back start edge is not missed.
          if (!TWO_STOP || stop_q) begin
            state_d = IDLE;
            commit  = 1'b1;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    done_d    = commit;
    data_d    = data_q;
    flags_d   = flags_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    if (commit) begin
      data_d  = shift_q;
      flags_d = cand_d;
    end
    // An ack in the commit cycle consumes the previous word, not the new one.
    if (done_q) begin
      pending_d = 1'b1;
      if (pending_q && !i_rd_ack) overrun_d = 1'b1;
    end else if (i_rd_ack) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      stop_q    <= 1'b0;
      shift_q   <= '0;
      data_q    <= '0;
      cand_q    <= '0;
      flags_q   <= '0;
      done_q    <= 1'b0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      stop_q    <= stop_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      cand_q    <= cand_d;
      flags_q   <= flags_d;
      done_q    <= done_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_rx_done    = done_q;
  assign o_data       = data_q;
  assign o_parity_err = flags_q.parity_err;
  assign o_frame_err  = flags_q.frame_err;
  assign o_break      = flags_q.brk;
  assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three configurations (8N1, 8E1, 32-bit two-stop)
// driven by serial frames built from the bit-level frame format.
module tb_uart_rx_cfg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       tick_const = 1'b0;
  logic [1:0] div = 2'd0;
  logic       tick;
  always @(posedge clk) div <= div + 2'd1;
  assign tick = tick_const | (div == 2'd0);

  logic [2:0]  rx_v = 3'b111;
  logic [2:0]  done_v, perr_v, ferr_v, brk_v, ovr_v, ack_v;
  logic [2:0]  auto_ack = 3'b000;
  logic [2:0]  man_ack = 3'b000;
  logic [7:0]  a_data, p_data;
  logic [31:0] w_data;

  assign ack_v = (auto_ack & done_v) | man_ack;

  uart_rx_cfg dut_a (
    .i_clk(clk), .i_reset(reset), .i_rx(rx_v[0]), .i_bd_tick(tick),
    .o_rx_done(done_v[0]), .o_data(a_data), .o_parity_err(perr_v[0]),
    .o_frame_err(ferr_v[0]), .o_break(brk_v[0]), .o_overrun(ovr_v[0]),
    .i_rd_ack(ack_v[0])
  );

  uart_rx_cfg #(.PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .i_clk(clk), .i_reset(reset), .i_rx(rx_v[1]), .i_bd_tick(tick),
    .o_rx_done(done_v[1]), .o_data(p_data), .o_parity_err(perr_v[1]),
    .o_frame_err(ferr_v[1]), .o_break(brk_v[1]), .o_overrun(ovr_v[1]),
    .i_rd_ack(ack_v[1])
  );

  uart_rx_cfg #(.DATA_BITS(32), .STOP_BITS(2)) dut_w (
    .i_clk(clk), .i_reset(reset), .i_rx(rx_v[2]), .i_bd_tick(tick),
    .o_rx_done(done_v[2]), .o_data(w_data), .o_parity_err(perr_v[2]),
    .o_frame_err(ferr_v[2]), .o_break(brk_v[2]), .o_overrun(ovr_v[2]),
    .i_rd_ack(ack_v[2])
  );

  int n_err = 0;
  int n_chk = 0;

  function automatic logic [31:0] data_of(input int sel);
    case (sel)
      0:       return {24'b0, a_data};
      1:       return {24'b0, p_data};
      default: return w_data;
    endcase
  endfunction

  // Completion monitor: counts o_rx_done pulses and captures what they publish.
  int          done_cnt [3] = '{0, 0, 0};
  logic [31:0] cap_data [3] = '{32'h0, 32'h0, 32'h0};
  logic [2:0]  cap_perr = 3'b0, cap_ferr = 3'b0, cap_brk = 3'b0;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done_v[i]) begin
        done_cnt[i]++;
        cap_data[i] = data_of(i);
        cap_perr[i] = perr_v[i];
        cap_ferr[i] = ferr_v[i];
        cap_brk[i]  = brk_v[i];
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got still running, expected finished");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int bitp();
    return tick_const ? 16 : 64;
  endfunction

  task automatic drive_bit(input int sel, input logic v, input int n);
    rx_v[sel] = v;
    cyc(n);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(1);
  endtask

  // A low final stop bit is released at 3/4 bit so the receiver's re-armed
  // start detector deterministically sees a glitch.
  task automatic send_frame(input int sel, input logic [31:0] d, input int nbits,
                            input bit has_par, input logic pbit, input int nstop,
                            input logic s0, input logic s1);
    int   bp;
    logic sv;
    bp = bitp();
    drive_bit(sel, 1'b0, bp);
    for (int i = 0; i < nbits; i++) drive_bit(sel, d[i], bp);
    if (has_par) drive_bit(sel, pbit, bp);
    for (int k = 0; k < nstop; k++) begin
      sv = (k == 0) ? s0 : s1;
      if (!sv && (k == nstop - 1)) begin
        drive_bit(sel, 1'b0, (bp * 3) / 4);
        drive_bit(sel, 1'b1, bp / 4);
      end else begin
        drive_bit(sel, sv, bp);
      end
    end
  endtask

  task automatic check_frame(input string tag, input int sel, input int n0,
                             input logic [31:0] ed, input logic ep,
                             input logic ef, input logic eb);
    chk($sformatf("%s done count", tag), done_cnt[sel] - n0, 1);
    chk($sformatf("%s data", tag), cap_data[sel], ed);
    chk($sformatf("%s parity_err", tag), {31'b0, cap_perr[sel]}, {31'b0, ep});
    chk($sformatf("%s frame_err", tag), {31'b0, cap_ferr[sel]}, {31'b0, ef});
    chk($sformatf("%s break", tag), {31'b0, cap_brk[sel]}, {31'b0, eb});
  endtask

  typedef struct {
    int          sel;
    logic [31:0] d;
    logic        pbit;
    logic        s0;
    logic [31:0] ed;
    logic        ep;
    logic        ef;
    logic        eb;
  } vec_t;

  vec_t vt [7];

  initial begin
    int          n0;
    logic [31:0] d;
    logic        pbit, s0, ep, ef, eb;
    int          sel, mode;
    logic [1:0]  m_pend, m_ovr;

    vt[0] = '{1, 32'h07, 1'b0, 1'b1, 32'h07, 1'b1, 1'b0, 1'b0};
    vt[1] = '{1, 32'h07, 1'b1, 1'b1, 32'h07, 1'b0, 1'b0, 1'b0};
    vt[2] = '{0, 32'h3C, 1'b0, 1'b0, 32'h3C, 1'b0, 1'b1, 1'b0};
    vt[3] = '{1, 32'h00, 1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 1'b1};
    vt[4] = '{1, 32'hFF, 1'b0, 1'b1, 32'hFF, 1'b0, 1'b0, 1'b0};
    vt[5] = '{1, 32'h80, 1'b0, 1'b1, 32'h80, 1'b1, 1'b0, 1'b0};
    vt[6] = '{0, 32'h55, 1'b0, 1'b1, 32'h55, 1'b0, 1'b0, 1'b0};

    cyc(3);
    reset = 1'b0;
    cyc(2);
    chk("reset a data", {24'b0, a_data}, 32'h0);
    chk("reset w data", w_data, 32'h0);
    chk("reset done", {29'b0, done_v}, 32'h0);
    chk("reset flags", {20'b0, perr_v, ferr_v, brk_v, ovr_v}, 32'h0);

    auto_ack = 3'b111;
    n0 = done_cnt[0];
    send_frame(0, 32'hA5, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    drive_bit(0, 1'b1, 2 * bitp());
    check_frame("a5", 0, n0, 32'hA5, 1'b0, 1'b0, 1'b0);

    n0 = done_cnt[0];
    drive_bit(0, 1'b0, 12);
    drive_bit(0, 1'b1, 3 * bitp());
    chk("glitch done count", done_cnt[0] - n0, 0);
    chk("glitch data held", {24'b0, a_data}, 32'hA5);
    chk("glitch flags held", {29'b0, perr_v[0], ferr_v[0], brk_v[0]}, 32'h0);

    for (int i = 0; i < 7; i++) begin
      n0 = done_cnt[vt[i].sel];
      send_frame(vt[i].sel, vt[i].d, 8, vt[i].sel == 1, vt[i].pbit, 1, vt[i].s0, 1'b1);
      drive_bit(vt[i].sel, 1'b1, 2 * bitp());
      check_frame($sformatf("vec%0d", i), vt[i].sel, n0, vt[i].ed, vt[i].ep, vt[i].ef, vt[i].eb);
    end

    // Break: line low through start, data and stop, then held low a while.
    n0 = done_cnt[0];
    drive_bit(0, 1'b0, 10 * bitp());
    chk("break done count", done_cnt[0] - n0, 1);
    chk("break data", cap_data[0], 32'h0);
    chk("break flag", {31'b0, cap_brk[0]}, 32'h1);
    chk("break frame_err", {31'b0, cap_ferr[0]}, 32'h1);
    drive_bit(0, 1'b0, 3 * bitp());
    drive_bit(0, 1'b1, 14 * bitp());
    n0 = done_cnt[0];
    send_frame(0, 32'h55, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    drive_bit(0, 1'b1, 2 * bitp());
    check_frame("after break", 0, n0, 32'h55, 1'b0, 1'b0, 1'b0);

    do_reset();
    auto_ack[0] = 1'b0;
    n0 = done_cnt[0];
    send_frame(0, 32'h11, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    send_frame(0, 32'h22, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    drive_bit(0, 1'b1, 2 * bitp());
    chk("b2b done count", done_cnt[0] - n0, 2);
    chk("b2b overrun", {31'b0, ovr_v[0]}, 32'h1);
    chk("b2b data", {24'b0, a_data}, 32'h22);

    do_reset();
    send_frame(0, 32'h11, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    drive_bit(0, 1'b1, bitp());
    man_ack[0] = 1'b1;
    cyc(1);
    man_ack[0] = 1'b0;
    send_frame(0, 32'h22, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    drive_bit(0, 1'b1, 2 * bitp());
    chk("acked overrun", {31'b0, ovr_v[0]}, 32'h0);
    chk("acked data", {24'b0, a_data}, 32'h22);

    // Ack in the commit cycle leaves the new word pending.
    do_reset();
    auto_ack[0] = 1'b1;
    send_frame(0, 32'h33, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    drive_bit(0, 1'b1, bitp());
    chk("same-cycle ack no overrun", {31'b0, ovr_v[0]}, 32'h0);
    auto_ack[0] = 1'b0;
    send_frame(0, 32'h44, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    drive_bit(0, 1'b1, bitp());
    chk("pending kept overrun", {31'b0, ovr_v[0]}, 32'h1);

    auto_ack = 3'b111;
    n0 = done_cnt[2];
    send_frame(2, 32'hDEADBEEF, 32, 1'b0, 1'b0, 2, 1'b1, 1'b1);
    drive_bit(2, 1'b1, 2 * bitp());
    check_frame("wide", 2, n0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);

    n0 = done_cnt[2];
    d = 32'h0000_2A5A;
    drive_bit(2, 1'b0, bitp());
    for (int i = 0; i < 12; i++) drive_bit(2, d[i], bitp());
    drive_bit(2, d[12], bitp() / 2);
    rx_v[2] = 1'b1;
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    cyc(3 * bitp());
    chk("abort done count", done_cnt[2] - n0, 0);
    chk("abort data", w_data, 32'h0);
    n0 = done_cnt[2];
    send_frame(2, 32'h12345678, 32, 1'b0, 1'b0, 2, 1'b1, 1'b1);
    drive_bit(2, 1'b1, 2 * bitp());
    check_frame("post abort", 2, n0, 32'h12345678, 1'b0, 1'b0, 1'b0);

    // Randomised frames, i_bd_tick held high, against a frame-level model.
    do_reset();
    tick_const = 1'b1;
    m_pend = 2'b00;
    m_ovr  = 2'b00;
    for (int it = 0; it < 24; it++) begin
      sel  = $urandom_range(0, 1);
      d    = {24'b0, 8'($urandom)};
      if ($urandom_range(0, 7) == 0) d = 32'h0;
      pbit = 1'($urandom_range(0, 1));
      s0   = ($urandom_range(0, 3) != 0);
      mode = $urandom_range(0, 2);
      if (mode == 1) begin
        man_ack[sel] = 1'b1;
        cyc(1);
        man_ack[sel] = 1'b0;
        m_pend[sel] = 1'b0;
      end
      auto_ack[sel] = (mode == 2);
      if (m_pend[sel] && (mode != 2)) m_ovr[sel] = 1'b1;
      m_pend[sel] = 1'b1;
      ep = (sel == 1) ? ((^d[7:0]) ^ pbit) : 1'b0;
      ef = !s0;
      eb = (d == 32'h0) && !s0;
      n0 = done_cnt[sel];
      send_frame(sel, d, 8, sel == 1, pbit, 1, s0, 1'b1);
      drive_bit(sel, 1'b1, 2 * bitp());
      check_frame($sformatf("rand%0d", it), sel, n0, d, ep, ef, eb);
      chk($sformatf("rand%0d overrun", it), {31'b0, ovr_v[sel]}, {31'b0, m_ovr[sel]});
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
